// File: rtl/axi_rw_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rw_arbiter
// Address-phase arbiter for the shared AXI read/write path. One master at a
// time owns the path for a complete transaction: the grant is raised when a
// request is accepted in IDLE and held until the last handshake of that
// transaction (r_last_hs for reads, b_hs for writes).
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   rst        asynchronous, active-low reset
//   arvalid    per-master ARVALID requests
//   awvalid    per-master AWVALID requests
//   ar_hs      AR handshake of the granted master
//   r_last_hs  final R beat handshake of the granted master
//   aw_hs      AW handshake of the granted master
//   w_last_hs  final W beat handshake of the granted master
//   b_hs       B response handshake of the granted master
//   ar_gnt     one-hot read grant (registered)
//   aw_gnt     one-hot write grant (registered)
//   gnt_id     index of the granted master, 0 when idle (registered)
//   rd_busy    a read transaction is in progress
//   wr_busy    a write transaction is in progress
// ---------------------------------------------------------------------------
module axi_rw_arbiter #(
   parameter int NUM_M = 2,
   parameter bit RR_EN = 1'b1,
   parameter int IDW   = $clog2(NUM_M)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NUM_M-1:0] arvalid,
   input  logic [NUM_M-1:0] awvalid,
   input  logic             ar_hs,
   input  logic             r_last_hs,
   input  logic             aw_hs,
   input  logic             w_last_hs,
   input  logic             b_hs,
   output logic [NUM_M-1:0] ar_gnt,
   output logic [NUM_M-1:0] aw_gnt,
   output logic [IDW-1:0]   gnt_id,
   output logic             rd_busy,
   output logic             wr_busy
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_ADDR = 3'd1;
   localparam logic [2:0] RD_DATA = 3'd2;
   localparam logic [2:0] WR_ADDR = 3'd3;
   localparam logic [2:0] WR_DATA = 3'd4;
   localparam logic [2:0] WR_RESP = 3'd5;

   logic [2:0]       state_q,  state_d;
   logic [NUM_M-1:0] ar_gnt_q, ar_gnt_d;
   logic [NUM_M-1:0] aw_gnt_q, aw_gnt_d;
   logic [IDW-1:0]   gnt_id_q, gnt_id_d;
   logic [IDW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [IDW-1:0]   wr_ptr_q, wr_ptr_d;
   // Set when the write channel should win the next read/write contention.
   // It comes out of reset set (write wins first) and afterwards favours the
   // channel that did not receive the previous grant.
   logic             wr_pref_q, wr_pref_d;

   logic             rd_found, wr_found;
   logic [IDW-1:0]   rd_idx,   wr_idx;

   // Returns {found, index}. Round-robin searches upward from ptr with
   // wrap-around; fixed priority lets the highest requesting index win.
   function automatic logic [IDW:0] pick(input logic [NUM_M-1:0] req,
                                         input logic [IDW-1:0]   ptr);
      logic           found;
      logic [IDW-1:0] idx;
      logic [IDW-1:0] cand;
      found = 1'b0;
      idx   = '0;
      if (RR_EN) begin
         for (int k = 0; k < NUM_M; k++) begin
            cand = IDW'((int'(ptr) + k) % NUM_M);
            if (!found && req[cand]) begin
               found = 1'b1;
               idx   = cand;
            end
         end
      end else begin
         for (int i = 0; i < NUM_M; i++) begin
            if (req[i]) begin
               found = 1'b1;
               idx   = IDW'(i);
            end
         end
      end
      return {found, idx};
   endfunction

   function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] idx);
      return IDW'((int'(idx) + 1) % NUM_M);
   endfunction

   function automatic logic [NUM_M-1:0] one_hot(input logic [IDW-1:0] idx);
      return {{(NUM_M-1){1'b0}}, 1'b1} << idx;
   endfunction

   assign {rd_found, rd_idx} = pick(arvalid, rd_ptr_q);
   assign {wr_found, wr_idx} = pick(awvalid, wr_ptr_q);

   // Transaction FSM. Requests are only looked at in IDLE; inside a
   // transaction only the handshake that ends the current phase matters.
   always_comb begin
      state_d   = state_q;
      ar_gnt_d  = ar_gnt_q;
      aw_gnt_d  = aw_gnt_q;
      gnt_id_d  = gnt_id_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      wr_pref_d = wr_pref_q;
      case (state_q)
         IDLE: begin
            if (rd_found && (!wr_found || !wr_pref_q)) begin
               state_d   = RD_ADDR;
               ar_gnt_d  = one_hot(rd_idx);
               gnt_id_d  = rd_idx;
               rd_ptr_d  = next_ptr(rd_idx);
               wr_pref_d = 1'b1;
            end else if (wr_found) begin
               state_d   = WR_ADDR;
               aw_gnt_d  = one_hot(wr_idx);
               gnt_id_d  = wr_idx;
               wr_ptr_d  = next_ptr(wr_idx);
               wr_pref_d = 1'b0;
            end
         end
         RD_ADDR: if (ar_hs) state_d = RD_DATA;
         RD_DATA: begin
            if (r_last_hs) begin
               state_d  = IDLE;
               ar_gnt_d = '0;
               gnt_id_d = '0;
            end
         end
         WR_ADDR: if (aw_hs)     state_d = WR_DATA;
         WR_DATA: if (w_last_hs) state_d = WR_RESP;
         WR_RESP: begin
            if (b_hs) begin
               state_d  = IDLE;
               aw_gnt_d = '0;
               gnt_id_d = '0;
            end
         end
         default: begin
            state_d  = IDLE;
            ar_gnt_d = '0;
            aw_gnt_d = '0;
            gnt_id_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         ar_gnt_q  <= '0;
         aw_gnt_q  <= '0;
         gnt_id_q  <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         wr_pref_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         ar_gnt_q  <= ar_gnt_d;
         aw_gnt_q  <= aw_gnt_d;
         gnt_id_q  <= gnt_id_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         wr_pref_q <= wr_pref_d;
      end
   end

   assign ar_gnt  = ar_gnt_q;
   assign aw_gnt  = aw_gnt_q;
   assign gnt_id  = gnt_id_q;
   assign rd_busy = (state_q == RD_ADDR) || (state_q == RD_DATA);
   assign wr_busy = (state_q == WR_ADDR) || (state_q == WR_DATA) ||
                    (state_q == WR_RESP);

endmodule
